// File: rtl/cpu_step_controller_if.sv
// cpu_step_controller_if: board-side inputs and pipeline/debug outputs of the step controller
//  master: drives step_btn_i, run_sw_i, bp_en_i, bp_addr_i, pc_i; observes the outputs
//  slave:  the controller; drives cpu_tick_o, state_o, halted_o, cycle_count_o
interface cpu_step_controller_if #(parameter int CNT_W = 32);
  logic step_btn_i;
  logic run_sw_i;
  logic bp_en_i;
  logic [31:0] bp_addr_i;
  logic [31:0] pc_i;
  logic cpu_tick_o;
  logic [1:0] state_o;
  logic halted_o;
  logic [CNT_W-1:0] cycle_count_o;
  modport master (
    output step_btn_i, run_sw_i, bp_en_i, bp_addr_i, pc_i,
    input cpu_tick_o, state_o, halted_o, cycle_count_o
  );
  modport slave (
    input step_btn_i, run_sw_i, bp_en_i, bp_addr_i, pc_i,
    output cpu_tick_o, state_o, halted_o, cycle_count_o
  );
endinterface

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: one-cycle pipeline advance pulses from single-step, free-run and PC breakpoint halt
//  clock, reset : system clock, asynchronous active-high reset
//  ctl (slave)  : step_btn_i/run_sw_i raw board inputs, bp_en_i/bp_addr_i breakpoint, pc_i current PC;
//                 cpu_tick_o advance enable, state_o FSM state, halted_o, cycle_count_o saturating tick count
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV = 50000000,
  parameter int CNT_W = 32
) (
  input logic clock,
  input logic reset,
  cpu_step_controller_if.slave ctl
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(RUN_DIV);
  localparam logic [1:0] IDLE = 2'b00, STEP = 2'b01, RUN = 2'b10, HALT = 2'b11;
  logic [1:0] step_sync_q, run_sync_q;
  logic step_db_q, step_db_d, run_db_q, run_db_d;
  logic step_done, run_done;
  logic [DW-1:0] step_cnt_q, step_cnt_d, run_cnt_q, run_cnt_d;
  logic step_prev_q, step_req_q;
  logic [VW-1:0] div_q, div_d;
  logic [1:0] state_q, state_d;
  logic cpu_tick_q, cpu_tick_d, halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic due, bp_hit;
  // A level flips only after the synced input has disagreed with it for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    step_done = step_sync_q[1] != step_db_q && step_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
    step_cnt_d = step_sync_q[1] != step_db_q && !step_done ? step_cnt_q + 1'b1 : '0;
    step_db_d = step_done ? step_sync_q[1] : step_db_q;
    run_done = run_sync_q[1] != run_db_q && run_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
    run_cnt_d = run_sync_q[1] != run_db_q && !run_done ? run_cnt_q + 1'b1 : '0;
    run_db_d = run_done ? run_sync_q[1] : run_db_q;
    due = state_q == RUN && div_q == VW'(RUN_DIV - 1);
    bp_hit = ctl.bp_en_i && ctl.pc_i == ctl.bp_addr_i;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = run_db_q ? RUN : step_req_q ? STEP : IDLE;
      STEP: state_d = IDLE;
      RUN: state_d = due && bp_hit ? HALT : !run_db_q ? IDLE : RUN;
      HALT: state_d = step_req_q ? STEP : !run_db_q ? IDLE : HALT;
    endcase
  end
  // A due tick is still issued on the cycle RUN is left for IDLE; only the breakpoint suppresses it.
  always_comb begin
    cpu_tick_d = state_d == STEP || (due && !bp_hit);
    halted_d = state_d == HALT;
    div_d = state_q == RUN && state_d == RUN ? (due ? '0 : div_q + 1'b1) : '0;
    count_d = cpu_tick_q && count_q != '1 ? count_q + 1'b1 : count_q;
  end
  // step_req_q is delayed one cycle past the debounced edge, so the tick lands DEBOUNCE_CYCLES+3 edges after the first sampling edge.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      step_sync_q <= '0;
      run_sync_q <= '0;
      step_db_q <= 1'b0;
      run_db_q <= 1'b0;
      step_cnt_q <= '0;
      run_cnt_q <= '0;
      step_prev_q <= 1'b0;
      step_req_q <= 1'b0;
      div_q <= '0;
      cpu_tick_q <= 1'b0;
      halted_q <= 1'b0;
      count_q <= '0;
    end else begin
      step_sync_q <= {step_sync_q[0], ctl.step_btn_i};
      run_sync_q <= {run_sync_q[0], ctl.run_sw_i};
      step_db_q <= step_db_d;
      run_db_q <= run_db_d;
      step_cnt_q <= step_cnt_d;
      run_cnt_q <= run_cnt_d;
      step_prev_q <= step_db_q;
      step_req_q <= step_db_q && !step_prev_q;
      div_q <= div_d;
      cpu_tick_q <= cpu_tick_d;
      halted_q <= halted_d;
      count_q <= count_d;
    end
  assign ctl.cpu_tick_o = cpu_tick_q;
  assign ctl.state_o = state_q;
  assign ctl.halted_o = halted_q;
  assign ctl.cycle_count_o = count_q;
endmodule
